// File: rtl/fpu_issue_ctrl.sv
// Issue stage in front of riscv_fpu: takes one request at a time, drives the FPU for a fixed
// latency, and returns {result, tag} pairs through a small response FIFO.
module fpu_issue_ctrl #(
  parameter int OP_W      = 32,
  parameter int RM_W      = 3,
  parameter int CMD_W     = 4,
  parameter int TAG_W     = 5,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [OP_W-1:0]  req_op_a_i,
  input  logic [OP_W-1:0]  req_op_b_i,
  input  logic [RM_W-1:0]  req_rm_i,
  input  logic [CMD_W-1:0] req_cmd_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [OP_W-1:0]  fpu_operand_a_o,
  output logic [OP_W-1:0]  fpu_operand_b_o,
  output logic [RM_W-1:0]  fpu_rm_o,
  output logic [CMD_W-1:0] fpu_operator_o,
  output logic             fpu_enable_o,
  output logic             fpu_stall_o,
  input  logic [OP_W-1:0]  fpu_result_i,
  input  logic             fpu_result_valid_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [OP_W-1:0]  rsp_result_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             busy_o,
  output logic             proto_err_o
);

  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int FCNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LATENCY - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RSP_DEPTH - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(RSP_DEPTH);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [OP_W-1:0]  r_opA;
  logic [OP_W-1:0]  r_opB;
  logic [RM_W-1:0]  r_rm;
  logic [CMD_W-1:0] r_cmd;
  logic [TAG_W-1:0] r_tag;
  logic             r_protoErr;

  logic [OP_W-1:0]   r_fifoRes [RSP_DEPTH];
  logic [TAG_W-1:0]  r_fifoTag [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [FCNT_W-1:0] r_count;

  logic w_exec;
  logic w_lastCycle;
  logic w_full;
  logic w_empty;
  logic w_stall;
  logic w_accept;
  logic w_capture;
  logic w_pop;

  assign w_exec      = (r_state == ST_EXEC);
  assign w_lastCycle = (r_cnt == CNT_LAST);
  assign w_full      = (r_count == FIFO_FULL);
  assign w_empty     = (r_count == '0);

  // Stall purely on a full FIFO; a pop in the same cycle does not free the slot early.
  assign w_stall   = w_exec & w_full;
  assign w_accept  = req_valid_i & req_ready_o;
  assign w_capture = w_exec & w_lastCycle & ~w_stall & ~flush_i;
  assign w_pop     = ~w_empty & rsp_ready_i & ~flush_i;

  assign req_ready_o     = (r_state == ST_IDLE) & ~flush_i;
  assign fpu_enable_o    = w_exec;
  assign fpu_stall_o     = w_stall;
  assign fpu_operand_a_o = r_opA;
  assign fpu_operand_b_o = r_opB;
  assign fpu_rm_o        = r_rm;
  assign fpu_operator_o  = r_cmd;

  assign rsp_valid_o  = ~w_empty;
  assign rsp_result_o = r_fifoRes[r_rdPtr];
  assign rsp_tag_o    = r_fifoTag[r_rdPtr];
  assign busy_o       = w_exec | ~w_empty;
  assign proto_err_o  = r_protoErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_EXEC;
            r_cnt   <= '0;
          end
        end
        ST_EXEC: begin
          // The counter freezes with the FPU's own pipeline whenever stall is raised.
          if (!w_stall) begin
            if (w_lastCycle) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opA <= '0;
      r_opB <= '0;
      r_rm  <= '0;
      r_cmd <= '0;
      r_tag <= '0;
    end else if (w_accept) begin
      r_opA <= req_op_a_i;
      r_opB <= req_op_b_i;
      r_rm  <= req_rm_i;
      r_cmd <= req_cmd_i;
      r_tag <= req_tag_i;
    end
  end

  // Sticky until reset; flush deliberately leaves the error flag alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_protoErr <= 1'b0;
    end else if (fpu_result_valid_i != (w_exec & w_lastCycle)) begin
      r_protoErr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_fifoRes[i] <= '0;
        r_fifoTag[i] <= '0;
      end
    end else if (w_capture) begin
      r_fifoRes[r_wrPtr] <= fpu_result_i;
      r_fifoTag[r_wrPtr] <= r_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_capture) begin
        r_wrPtr <= (r_wrPtr == PTR_LAST) ? '0 : r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == PTR_LAST) ? '0 : r_rdPtr + PTR_W'(1);
      end
      case ({w_capture, w_pop})
        2'b10:   r_count <= r_count + FCNT_W'(1);
        2'b01:   r_count <= r_count - FCNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
